// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding, default width and clog2 helper for the sqrt arbiter.
package arith_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    localparam int DEF_WIDTH = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sqrt_arbiter_if.sv
// sqrt_arbiter_if: requester-side and sqrt-side signals of the shared sqrt arbiter.
interface sqrt_arbiter_if
    import arith_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEF_WIDTH
);
    logic [NREQ-1:0]       req_bi;
    logic [NREQ*WIDTH-1:0] x_bi;
    logic [NREQ-1:0]       gnt_bo;
    logic [NREQ-1:0]       done_bo;
    logic [WIDTH-1:0]      y_bo;
    logic                  err_o;
    logic                  busy_o;
    logic                  sq_start_o;
    logic [WIDTH-1:0]      sq_x_bo;
    logic                  sq_busy_i;
    logic [WIDTH-1:0]      sq_y_bi;

    modport slave (
        input  req_bi, x_bi, sq_busy_i, sq_y_bi,
        output gnt_bo, done_bo, y_bo, err_o, busy_o, sq_start_o, sq_x_bo
    );

    modport master (
        output req_bi, x_bi, sq_busy_i, sq_y_bi,
        input  gnt_bo, done_bo, y_bo, err_o, busy_o, sq_start_o, sq_x_bo
    );
endinterface

// File: rtl/sqrt_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; searches upward from ptr_i+1, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (gnt_o == '0 && req_i[(int'(ptr_i) + i) % NREQ]) begin
                gnt_o[(int'(ptr_i) + i) % NREQ] = 1'b1;
                idx_o = IW'((int'(ptr_i) + i) % NREQ);
            end
        end
    end
endmodule

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin sequencer sharing one sqrt unit among NREQ requesters,
// with a saturating watchdog that turns a stalled sqrt into an error completion.
module sqrt_arbiter
    import arith_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = 64
) (
    input logic           clk_i,
    input logic           rst_i,
    sqrt_arbiter_if.slave bus
);
    localparam int IW = clog2(NREQ);
    localparam int WW = clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d, pick_idx;
    logic [NREQ-1:0]  pick_gnt;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic             err_q, err_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic             wd_exp;

    // The last granted index doubles as the round-robin pointer.
    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i (bus.req_bi),
        .ptr_i (idx_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    assign wd_exp = wd_q == WW'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        wd_d    = (wd_q == WW'(TIMEOUT)) ? wd_q : wd_q + 1'b1;
        unique case (state_q)
            IDLE: if (|bus.req_bi) begin
                state_d = ISSUE;
                idx_d   = pick_idx;
                x_d     = bus.x_bi[int'(pick_idx)*WIDTH +: WIDTH];
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: if (bus.sq_busy_i) begin
                wd_d    = '0;
                state_d = WAIT_DONE;
            end else if (wd_exp) begin
                state_d = RESP;
                err_d   = 1'b1;
                y_d     = '0;
            end
            WAIT_DONE: if (!bus.sq_busy_i) begin
                state_d = RESP;
                err_d   = 1'b0;
                y_d     = bus.sq_y_bi;
            end else if (wd_exp) begin
                state_d = RESP;
                err_d   = 1'b1;
                y_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= IW'(NREQ - 1);
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    // Grant is gated by reset so held requests cannot leak a grant while reset is asserted.
    assign bus.gnt_bo     = (state_q == IDLE && !rst_i) ? pick_gnt : '0;
    assign bus.done_bo    = (state_q == RESP) ? NREQ'(1) << idx_q : '0;
    assign bus.err_o      = (state_q == RESP) && err_q;
    assign bus.busy_o     = state_q != IDLE;
    assign bus.sq_start_o = state_q == ISSUE;
    assign bus.sq_x_bo    = x_q;
    assign bus.y_bo       = y_q;
endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: directed bench for sqrt_arbiter with a behavioural sqrt that can stall.
module tb_sqrt_arbiter;
    import arith_pkg::*;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;
    int   overlap = 0;
    int   stale = 0;
    int   mode = 0;

    sqrt_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    sqrt_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // mode 0: normal sqrt, 1: never starts, 2: busy stuck high
    logic             m_busy;
    logic [WIDTH-1:0] m_y, m_res;
    int               m_cnt;

    function automatic logic [WIDTH-1:0] isqrt(input logic [WIDTH-1:0] x);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return WIDTH'(r);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_y    <= '0;
            m_cnt  <= 0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0;
                m_y    <= m_res;
            end else m_cnt <= m_cnt - 1;
        end else if (bus.sq_start_o && mode != 1) begin
            m_busy <= 1'b1;
            m_cnt  <= LAT - 1;
            m_res  <= isqrt(bus.sq_x_bo);
        end
    end

    assign bus.sq_busy_i = (mode == 2) || m_busy;
    assign bus.sq_y_bi   = m_y;

    always @(negedge clk) if (|bus.gnt_bo && |bus.done_bo) overlap++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_x(input int k, input int v);
        bus.x_bi[k*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic serve(input int k, input int ex, input int ey, input int eerr, input int elat);
        int c;
        #1;
        c = 0;
        while (bus.gnt_bo == '0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("gnt", bus.gnt_bo, 1 << k);
        @(negedge clk);
        chk("start", bus.sq_start_o, 1);
        chk("sq_x", bus.sq_x_bo, ex);
        @(negedge clk);
        chk("start_pulse", bus.sq_start_o, 0);
        c = 2;
        while (bus.done_bo == '0 && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("done", bus.done_bo, 1 << k);
        chk("latency", c, elat);
        chk("y", bus.y_bo, ey);
        chk("err", bus.err_o, eerr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.req_bi = '0;
        bus.x_bi   = '0;
        @(negedge clk);
        chk("reset_outs", {bus.gnt_bo, bus.done_bo, bus.y_bo, bus.err_o, bus.busy_o,
                           bus.sq_start_o, bus.sq_x_bo}, 0);
        rst = 1'b0;
        @(negedge clk);

        set_x(0, 144);
        bus.req_bi = 4'b0001;
        serve(0, 144, 12, 0, 6);
        bus.req_bi = '0;
        @(negedge clk);
        chk("y_held", bus.y_bo, 12);
        chk("idle_busy", bus.busy_o, 0);
        chk("done_pulse", bus.done_bo, 0);

        do_reset();
        set_x(3, 255); set_x(2, 225); set_x(1, 1); set_x(0, 0);
        bus.req_bi = 4'b1111;
        serve(0, 0, 0, 0, 6);
        serve(1, 1, 1, 0, 6);
        serve(2, 225, 15, 0, 6);
        serve(3, 255, 15, 0, 6);
        bus.req_bi = '0;
        @(negedge clk);

        set_x(0, 16); set_x(2, 64);
        bus.req_bi = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) serve(0, 16, 4, 0, 6);
            else serve(2, 64, 8, 0, 6);
        end
        bus.req_bi = '0;
        @(negedge clk);

        set_x(0, 100);
        bus.req_bi = 4'b0001;
        #1;
        chk("mid_gnt", bus.gnt_bo, 1);
        @(negedge clk);
        bus.req_bi = '0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", bus.busy_o, 1);
        rst = 1'b1;
        #1;
        chk("mid_reset_outs", {bus.gnt_bo, bus.done_bo, bus.y_bo, bus.err_o, bus.busy_o,
                               bus.sq_start_o, bus.sq_x_bo}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done_bo != '0) stale++;
        end
        chk("stale_done", stale, 0);
        set_x(3, 81);
        bus.req_bi = 4'b1000;
        serve(3, 81, 9, 0, 6);
        bus.req_bi = '0;
        @(negedge clk);

        mode = 1;
        set_x(1, 200);
        bus.req_bi = 4'b0010;
        serve(1, 200, 0, 1, TIMEOUT + 2);
        bus.req_bi = '0;
        mode = 0;
        @(negedge clk);
        chk("to_idle", bus.busy_o, 0);

        set_x(2, 49);
        bus.req_bi = 4'b0100;
        serve(2, 49, 7, 0, 6);
        bus.req_bi = '0;
        @(negedge clk);

        mode = 2;
        set_x(1, 50);
        bus.req_bi = 4'b0010;
        serve(1, 50, 0, 1, TIMEOUT + 3);
        bus.req_bi = '0;
        mode = 0;
        @(negedge clk);
        chk("stuck_idle", bus.busy_o, 0);
        repeat (LAT + 2) @(negedge clk);

        set_x(0, 169);
        bus.req_bi = 4'b0001;
        serve(0, 169, 13, 0, 6);
        bus.req_bi = '0;
        @(negedge clk);

        chk("no_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
